// File: rtl/sat_round_arbiter.sv
// Round-robin arbiter over N_CH sample streams feeding a one-deep output register
// that rounds (half up) and saturates each accepted sample from NB_XI/NBF_XI to NB_XO/NBF_XO.
module sat_round_arbiter #(
  parameter int N_CH   = 4,
  parameter int NB_XI  = 20,
  parameter int NBF_XI = 12,
  parameter int NB_XO  = 8,
  parameter int NBF_XO = 6
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic [N_CH-1:0]             i_valid,
  input  logic [N_CH*NB_XI-1:0]       i_data,
  output logic [N_CH-1:0]             o_ready,
  output logic                        o_valid,
  output logic signed [NB_XO-1:0]     o_data,
  output logic [$clog2(N_CH)-1:0]     o_ch,
  output logic                        o_sat,
  input  logic                        i_ready,
  input  logic                        i_clr_cnt,
  output logic [15:0]                 o_sat_cnt,
  output logic                        o_busy
);

  localparam int CW = $clog2(N_CH);
  localparam int S  = NBF_XI - NBF_XO;
  localparam logic signed [NB_XI:0] MAXV = (NB_XI+1)'((2**(NB_XO-1)) - 1);
  localparam logic signed [NB_XI:0] MINV = (NB_XI+1)'(-(2**(NB_XO-1)));
  localparam logic signed [NB_XI:0] HALF = (NB_XI+1)'(2**(S-1));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // One extra bit of headroom so adding the half-LSB to the largest input cannot wrap.
  function automatic logic signed [NB_XI:0] round_shift(input logic signed [NB_XI-1:0] x);
    logic signed [NB_XI:0] sum;
    sum = $signed({x[NB_XI-1], x}) + HALF;
    return sum >>> S;
  endfunction

  // Returns {saturated, clamped value}.
  function automatic logic [NB_XO:0] saturate(input logic signed [NB_XI:0] v);
    if (v > MAXV)      return {1'b1, MAXV[NB_XO-1:0]};
    else if (v < MINV) return {1'b1, MINV[NB_XO-1:0]};
    else               return {1'b0, v[NB_XO-1:0]};
  endfunction

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_valid;
  logic signed [NB_XO-1:0]  r_data;
  logic [CW-1:0]            r_ch;
  logic                     r_sat;
  logic [CW-1:0]            r_ptr;
  logic [15:0]              r_cnt;

  logic                     w_slot_free;
  logic                     w_found;
  logic [CW-1:0]            w_gidx;
  logic [N_CH-1:0]          w_grant;
  logic                     w_accept;
  logic signed [NB_XI-1:0]  w_sel;
  logic [NB_XO:0]           w_q;

  assign w_slot_free = !r_valid || i_ready;

  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_gidx   = '0;
    w_grant  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(r_ptr) + i) % N_CH;
      if (!w_found && i_valid[idx]) begin
        w_found = 1'b1;
        w_gidx  = CW'(idx);
      end
    end
    if (r_state == RUN && w_slot_free && w_found) w_grant[w_gidx] = 1'b1;
  end

  assign w_accept = |w_grant;

  always_comb begin
    w_sel = i_data[w_gidx*NB_XI +: NB_XI];
    w_q   = saturate(round_shift(w_sel));
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_enable) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
        RUN: if (!i_enable) r_state <= DRAIN;
        DRAIN: begin
          if (i_enable) begin
            r_state <= RUN;
          end else if (!r_valid || i_ready) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load on accept, empty on downstream take, otherwise hold.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_sat   <= 1'b0;
      r_ptr   <= CW'(N_CH - 1);
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= w_q[NB_XO-1:0];
        r_sat   <= w_q[NB_XO];
        r_ch    <= w_gidx;
        r_ptr   <= w_gidx;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_clr_cnt)
        r_cnt <= '0;
      else if (w_accept && w_q[NB_XO] && r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_ready   = w_grant;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_ch      = r_ch;
  assign o_sat     = r_sat;
  assign o_sat_cnt = r_cnt;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_sat_round_arbiter.sv
// Directed plus randomized bench for sat_round_arbiter, checked against an
// integer-arithmetic model of the arbitration, quantization and FSM rules.
module tb_sat_round_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  vld = '0;
  logic [79:0] data = '0;
  logic [3:0]  rdy_o;
  logic        ov;
  logic [7:0]  od;
  logic [1:0]  och;
  logic        osat;
  logic        ir = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // model: state 0=IDLE 1=RUN 2=DRAIN
  int m_state, m_ptr, m_vld, m_data, m_ch, m_sat, m_cnt;

  sat_round_arbiter dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_valid(vld), .i_data(data),
    .o_ready(rdy_o), .o_valid(ov), .o_data(od), .o_ch(och), .o_sat(osat),
    .i_ready(ir), .i_clr_cnt(clr), .o_sat_cnt(cnt), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quant(input logic [19:0] raw, output int v, output int s);
    int x, q, f;
    x = int'($signed(raw));
    q = x + 32;
    f = (q >= 0) ? q / 64 : -((-q + 63) / 64);
    v = (f > 127) ? 127 : (f < -128) ? -128 : f;
    s = (v != f) ? 1 : 0;
  endtask

  function automatic int exp_grant();
    if (m_state != 1 || (m_vld != 0 && !ir)) return -1;
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (m_ptr + i) % 4;
      if (vld[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ptr = 3; m_vld = 0; m_data = 0; m_ch = 0; m_sat = 0; m_cnt = 0;
  endtask

  task automatic step(input bit full);
    int g, v, s, er, n_state, n_vld, n_data, n_ch, n_sat, n_ptr, n_cnt;
    @(negedge clk);
    g = exp_grant();
    er = (g >= 0) ? (1 << g) : 0;
    if (full) begin
      chk("ready", 32'(rdy_o), er);
      chk("busy", 32'(busy), (m_state != 0) ? 1 : 0);
    end
    n_vld = m_vld; n_data = m_data; n_ch = m_ch; n_sat = m_sat; n_ptr = m_ptr;
    n_cnt = m_cnt; n_state = m_state; s = 0;
    if (g >= 0) begin
      quant(data[g*20 +: 20], v, s);
      n_vld = 1; n_data = v & 255; n_ch = g; n_sat = s; n_ptr = g;
    end else if (ir) begin
      n_vld = 0;
    end
    if (clr) n_cnt = 0;
    else if (g >= 0 && s != 0 && m_cnt < 65535) n_cnt = m_cnt + 1;
    case (m_state)
      0: if (en) n_state = 1;
      1: if (!en) n_state = 2;
      default: if (en) n_state = 1; else if (m_vld == 0 || ir) n_state = 0;
    endcase
    @(posedge clk);
    #1;
    m_state = n_state; m_vld = n_vld; m_data = n_data; m_ch = n_ch;
    m_sat = n_sat; m_ptr = n_ptr; m_cnt = n_cnt;
    if (full) begin
      chk("o_valid", 32'(ov), m_vld);
      chk("o_data", 32'(od), m_data);
      chk("o_ch", 32'(och), m_ch);
      chk("o_sat", 32'(osat), m_sat);
      chk("o_sat_cnt", 32'(cnt), m_cnt);
    end
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(ov), 0);
    chk("rst_data", 32'(od), 0);
    chk("rst_ch", 32'(och), 0);
    chk("rst_sat", 32'(osat), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(rdy_o), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [19:0] rnd_raw [4] = '{20'h00020, 20'h0001F, 20'hFFFE0, 20'h01FE0};
  logic [7:0]  rnd_exp [4] = '{8'h01, 8'h00, 8'h00, 8'h7F};
  logic        rnd_sat [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [19:0] edge_v  [6] = '{20'h7FFFF, 20'h80000, 20'h01FE0, 20'h01FDF, 20'hFE020, 20'hFE01F};

  initial begin
    model_reset();
    #1;
    reset_mid();

    en = 1'b1;
    step(1);
    vld = 4'b0001; data[19:0] = 20'h01000; ir = 1'b1;
    step(1);
    chk("one_data", 32'(od), 32'h40);
    chk("one_ch", 32'(och), 0);
    chk("one_sat", 32'(osat), 0);

    for (int i = 0; i < 4; i++) begin
      data[19:0] = rnd_raw[i];
      step(1);
      chk("round_data", 32'(od), 32'(rnd_exp[i]));
      chk("round_sat", 32'(osat), 32'(rnd_sat[i]));
    end
    chk("round_cnt", 32'(cnt), 1);

    vld = 4'b0000; clr = 1'b1;
    step(1);
    clr = 1'b0;
    vld = 4'b0001; data[19:0] = 20'h7FFFF;
    step(1);
    chk("satpos_data", 32'(od), 32'h7F);
    chk("satpos_sat", 32'(osat), 1);
    data[19:0] = 20'h80000;
    step(1);
    chk("satneg_data", 32'(od), 32'h80);
    chk("satneg_sat", 32'(osat), 1);
    chk("sat_cnt2", 32'(cnt), 2);

    ir = 1'b0; vld = 4'b0000;
    chk("pre_rst_valid", 32'(ov), 1);
    reset_mid();

    en = 1'b1; ir = 1'b1;
    data = {20'h04000, 20'h03000, 20'h02000, 20'h01000};
    step(1);
    vld = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("rr_order", 32'(och), i % 4);
      chk("rr_valid", 32'(ov), 1);
    end
    ir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("hold_ready", 32'(rdy_o), 0);
      chk("hold_ch", 32'(och), 3);
      chk("hold_valid", 32'(ov), 1);
    end

    en = 1'b0;
    step(1);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_ready", 32'(rdy_o), 0);
    ir = 1'b1;
    step(1);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(ov), 0);

    for (int n = 0; n < 400; n++) begin
      en  = ($urandom % 8) != 0;
      vld = 4'($urandom);
      ir  = ($urandom % 4) != 0;
      clr = ($urandom % 32) == 0;
      for (int k = 0; k < 4; k++)
        data[k*20 +: 20] = ($urandom % 3 == 0) ? edge_v[$urandom % 6] : 20'($urandom);
      step(1);
    end

    en = 1'b1; vld = 4'hF; ir = 1'b1; clr = 1'b1;
    data = {4{20'h7FFFF}};
    step(1);
    clr = 1'b0;
    for (int n = 0; n < 65540; n++) step(0);
    chk("cnt_full", 32'(cnt), 32'hFFFF);
    step(1);
    chk("cnt_stick", 32'(cnt), 32'hFFFF);
    chk("cnt_stick_sat", 32'(osat), 1);
    clr = 1'b1;
    step(1);
    chk("cnt_clr_prio", 32'(cnt), 0);
    chk("cnt_clr_sat", 32'(osat), 1);
    clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sat_round_arbiter.md
SAT_ROUND_ARBITER -- requirements
Module: sat_round_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, number of requesting channels (2..8).
REQ-002 The block SHALL have parameters NB_XI/NBF_XI, defaults 20/12, input word width and fraction bits (signed two's complement).
REQ-003 The block SHALL have parameters NB_XO/NBF_XO, defaults 8/6, output word width and fraction bits; NBF_XI>NBF_XO and NB_XI-NBF_XI>=NB_XO-NBF_XO are required.
REQ-004 i_clock  input  1  sole clock, rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_enable  input  1  run request; low stops new grants.
REQ-007 i_valid  input  N_CH  per-channel sample valid.
REQ-008 i_data  input  N_CH*NB_XI  per-channel sample; channel k occupies bits [k*NB_XI +: NB_XI].
REQ-009 o_ready  output  N_CH  one-hot grant; channel k's sample is accepted in a cycle when i_valid[k] and o_ready[k] are both high.
REQ-010 o_valid  output  1  output sample valid.
REQ-011 o_data  output  NB_XO  quantized sample.
REQ-012 o_ch  output  clog2(N_CH)  source channel of o_data.
REQ-013 o_sat  output  1  o_data was saturated.
REQ-014 i_ready  input  1  downstream accepts o_data when o_valid and i_ready are both high.
REQ-015 i_clr_cnt  input  1  synchronous clear of o_sat_cnt.
REQ-016 o_sat_cnt  output  16  count of saturated accepted samples.
REQ-017 o_busy  output  1  high in states RUN and DRAIN.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN: IDLE->RUN when i_enable=1; RUN->DRAIN when i_enable=0; DRAIN->IDLE when the output register is empty (o_valid=0 or output handshake this cycle); DRAIN->RUN when i_enable=1.
REQ-019 Grants SHALL be issued only in RUN, and only when the output slot is free (o_valid=0 or i_ready=1); o_ready SHALL be combinational from the current state and inputs, at most one bit set.
REQ-020 Arbitration SHALL be round-robin: search starts at channel (last_granted+1) mod N_CH, wrapping; the first channel with i_valid=1 is granted; the pointer updates only on an accepted transfer.
REQ-021 The pointer SHALL reset to N_CH-1, giving channel 0 first priority.
REQ-022 Quantization SHALL use S=NBF_XI-NBF_XO: add 2^(S-1) in NB_XI+1-bit signed arithmetic (round half up toward +inf), arithmetic shift right by S, then saturate to [-2^(NB_XO-1), 2^(NB_XO-1)-1].
REQ-023 o_sat SHALL be 1 when the clamp in REQ-022 changed the value, including overflow caused by rounding.
REQ-024 Latency SHALL be 1 cycle: an accepted sample SHALL appear on o_data/o_ch/o_sat/o_valid at the next rising edge.
REQ-025 While o_valid=1 and i_ready=0, o_data, o_ch, o_sat and o_valid SHALL hold stable.
REQ-026 Back-to-back operation SHALL sustain one sample per cycle when i_ready stays high.
REQ-027 o_sat_cnt SHALL increment by 1 per accepted sample with o_sat=1 (counted at acceptance) and SHALL stick at 0xFFFF; i_clr_cnt SHALL have priority and set it to 0 even if an increment coincides.
REQ-028 i_valid deasserted by a requester without a grant SHALL have no effect; no sample is lost or duplicated.

Reset
REQ-029 Asserting i_reset low SHALL immediately force: state IDLE, o_valid=0, o_data=0, o_ch=0, o_sat=0, o_sat_cnt=0, pointer=N_CH-1; o_ready=0 and o_busy=0 follow.
REQ-030 Reset mid-transfer SHALL discard the pending output sample; operation resumes from IDLE after reset release.

Verification (defaults N_CH=4, 20/12 -> 8/6)
REQ-031 Ch0 sends 0x01000 (1.0), i_ready=1 -> next cycle o_data=0x40, o_ch=0, o_sat=0.
REQ-032 Rounding: 0x00020 -> 0x01; 0x0001F -> 0x00; 0xFFFE0 -> 0x00; 0x01FE0 -> 0x7F with o_sat=1 and o_sat_cnt incremented by 1.
REQ-033 Saturation: 0x7FFFF -> 0x7F with o_sat=1; 0x80000 -> 0x80 with o_sat=1; o_sat_cnt=2.
REQ-034 All four channels valid continuously, i_ready=1 -> grant order 0,1,2,3,0,... with one output per cycle; with i_ready=0 for 3 cycles, the output holds and no grant is issued.
REQ-035 i_enable dropped while o_valid=1 and i_ready=0 -> state DRAIN, no grants, o_busy=1; i_ready=1 -> state IDLE next cycle, o_busy=0.
REQ-036 Reset asserted with o_valid=1 -> all outputs 0 immediately; o_sat_cnt=0xFFFF plus a saturating sample -> stays 0xFFFF; i_clr_cnt together with a saturating sample -> 0.
